// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the clean, clk-synchronous button level into single-cycle event
// pulses (press, release, short press, long press, double click) and keeps
// a wrapping count of presses. All outputs are registered.
module button_event_decoder #(
  parameter int LONG_CYCLES = 10_000_000,  // high samples that make a long press
  parameter int GAP_CYCLES  = 3_000_000,   // low samples allowed between double-click presses
  parameter int CNT_W       = 24           // must hold max(LONG_CYCLES, GAP_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,            // asynchronous, active low
  input  logic       btn_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    LONG   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  // Terminal counts: the rise/fall edge itself is sample 1, so the event
  // fires when the counter already holds N-1 and one more sample arrives.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_q;
  logic             rise;
  logic             fall;

  // btn_q resets to 1 so a button held through reset release is not a press.
  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;

  // Edge pulses and press counter; a fall seen in IDLE belongs to a press
  // that was never accepted (held through reset) and is suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      btn_q         <= btn_in;
      press_pulse   <= rise;
      release_pulse <= fall && (state != IDLE);
      if (rise) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  // Interaction classifier with registered short/long/double pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            cnt   <= CNT_ONE;
          end
        end

        PRESS1: begin
          // A release on the terminal sample is still a release.
          if (!btn_in) begin
            state <= GAP;
            cnt   <= CNT_ONE;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LONG: begin
          if (fall) begin
            state <= IDLE;
          end
        end

        GAP: begin
          // A second press on the terminal gap sample wins over short_press.
          if (rise) begin
            state <= PRESS2;
            cnt   <= CNT_ONE;
          end else if (cnt == GAP_LAST) begin
            state       <= IDLE;
            short_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESS2: begin
          if (fall) begin
            state        <= IDLE;
            double_click <= 1'b1;
          end else if (btn_in && (cnt == LONG_LAST)) begin
            // Holding the second press too long cancels the double click.
            state      <= LONG;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the button antirrebote/synchronizer stage.
- Consumes its clean, clk-synchronous level and classifies each interaction into single-cycle event pulses: press, release, short press, long press, double click.
- Also keeps a wrapping press counter.
- Feeds the control FSMs and display logic, which act on events rather than levels.

Parameters:
- LONG_CYCLES, 10_000_000, number of consecutive high samples that qualify a long press (1 s at 10 MHz). Must be >= 2.
- GAP_CYCLES, 3_000_000, number of consecutive low samples after a short release within which a second press makes a double click (300 ms at 10 MHz). Must be >= 2.
- CNT_W, 24, width of the internal cycle counter. Must satisfy 2^CNT_W > max(LONG_CYCLES, GAP_CYCLES).

Ports:
- clk  input  1  system clock, 10 MHz.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- btn_in  input  1  debounced, already synchronized button level (1 = pressed).
- press_pulse  output  1  one-cycle pulse on each rising edge of btn_in.
- release_pulse  output  1  one-cycle pulse on each falling edge of btn_in.
- short_press  output  1  one-cycle pulse: single short click confirmed.
- long_press  output  1  one-cycle pulse: hold reached LONG_CYCLES.
- double_click  output  1  one-cycle pulse: second short click completed.
- press_count  output  8  number of press_pulse events, modulo 256.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, cnt=0, btn_q=1.
- All pulse outputs 0; press_count=0.
- btn_q resetting to 1 means a button held through reset release produces no press; its later fall is ignored in IDLE.
- Reset mid-sequence aborts it; no event is emitted.

Edge detection:
- btn_q <= btn_in every edge.
- rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.

Output timing:
- All outputs are registered.
- A pulse is high for exactly the one cycle following the edge at which its cause is sampled.
- press_pulse/release_pulse follow rise/fall in every state except the IDLE-fall case above.
- press_count += 1 on each press_pulse; it wraps 255 -> 0.

FSM (evaluated at each clk edge):
- IDLE: rise -> PRESS1, cnt<=1. Otherwise stay.
- PRESS1:
  - btn_in=1 and cnt==LONG_CYCLES-1 -> LONG, assert long_press.
  - btn_in=1 otherwise -> cnt++.
  - fall -> GAP, cnt<=1.
- LONG: fall -> IDLE. No short_press or double_click for this press.
- GAP:
  - rise -> PRESS2, cnt<=1.
  - else cnt==GAP_CYCLES-1 -> IDLE, assert short_press.
  - else cnt++.
- PRESS2:
  - fall -> IDLE, assert double_click (no short_press for either click).
  - btn_in=1 and cnt==LONG_CYCLES-1 -> LONG, assert long_press (double click cancelled, no short_press).
  - else cnt++.

Counting semantics:
- The rise edge counts as sample 1. long_press fires at the edge of the LONG_CYCLES-th consecutive high sample.
- The fall edge counts as gap sample 1. short_press fires at the edge of the GAP_CYCLES-th consecutive low sample.

Boundary cases:
- In GAP, a rise at the same edge where cnt==GAP_CYCLES-1 takes priority: -> PRESS2, no short_press.
- In PRESS1/PRESS2, a fall at the same edge where cnt==LONG_CYCLES-1 is a release (btn_in=0), not a long press.
- At most one of short_press/long_press/double_click is ever high in a cycle.
- press_pulse may coincide with nothing else except release_pulse, which is impossible on the same edge.
- cnt never exceeds max(LONG_CYCLES, GAP_CYCLES)-1.

Test Plan:
Sim parameters: LONG_CYCLES=8, GAP_CYCLES=6.
1. Short single: hold 3 cycles, release, idle 10 -> press_pulse, release_pulse 3 cycles later, short_press exactly 6 low samples after the fall; press_count=1.
2. Long: hold 12 cycles -> long_press at the 8th high sample; release -> release_pulse only, no short_press; press_count=1.
3. Double: high 2, low 3, high 2, low -> two press_pulses, double_click one cycle after the second fall, no short_press; press_count=2.
4. Gap boundary: high 2, low exactly 5 then rise -> double path. Repeat with low 6 -> short_press fires, and the next rise is treated as a new PRESS1.
5. Reset: pull rst low mid-PRESS1 with btn_in held, release rst -> no pulses until the button is released and pressed again; press_count restarts at 0.
6. Wrap: 256 short presses -> press_count returns to 0; 257th -> 1.
